// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot pixel scanner: default fixed-point
// format, default screen resolution, the scanner FSM state type and a small
// helper that sizes counters.
package mandelbrot_pkg;

  localparam int DEF_BIT_WIDTH       = 32;
  localparam int DEF_FLOAT_PRECISION = 24;
  localparam int DEF_H_RES           = 640;
  localparam int DEF_V_RES           = 480;
  localparam int DEF_ADDR_W          = 19;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ACC = 3'd2,
    WAIT_RES = 3'd3,
    WRITE    = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Width needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mandelbrot_pixel_scanner_if.sv
// Bus between the pixel scanner, the Mandelbrot iteration core and the frame
// buffer.
//
// Handshakes:
//  - Core input: calc_start is asserted only while calc_rdy is high; the core
//    takes calc_real/calc_imag on a clock edge with calc_start && calc_rdy and
//    then drops calc_rdy. A result is complete when calc_rdy and calc_out_rdy
//    are both high after that drop; calc_colour is valid then.
//  - Frame buffer: fb_we is a valid flag, fb_ready its ready. A write transfers
//    on a clock edge with fb_we && fb_ready. While fb_we is high and fb_ready
//    low, fb_addr and fb_data are held stable.
interface mandelbrot_pixel_scanner_if
  import mandelbrot_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int ADDR_W    = DEF_ADDR_W
);

  logic [BIT_WIDTH-1:0] calc_real;
  logic [BIT_WIDTH-1:0] calc_imag;
  logic                 calc_start;
  logic                 calc_rdy;
  logic                 calc_out_rdy;
  logic [BIT_WIDTH-1:0] calc_colour;

  logic [ADDR_W-1:0]    fb_addr;
  logic [BIT_WIDTH-1:0] fb_data;
  logic                 fb_we;
  logic                 fb_ready;

  // Scanner side.
  modport master (
    output calc_real, calc_imag, calc_start,
    input  calc_rdy, calc_out_rdy, calc_colour,
    output fb_addr, fb_data, fb_we,
    input  fb_ready
  );

  // Core / frame-buffer side.
  modport slave (
    input  calc_real, calc_imag, calc_start,
    output calc_rdy, calc_out_rdy, calc_colour,
    input  fb_addr, fb_data, fb_we,
    output fb_ready
  );

endinterface

// File: rtl/mandelbrot_coord_stepper.sv
// Raster position tracker: x/y counters, linear frame-buffer address and the
// current complex coordinate. Coordinates move by repeated add/subtract of the
// step so no multiplier is needed; arithmetic wraps in two's complement.
module mandelbrot_coord_stepper
  import mandelbrot_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int H_RES     = DEF_H_RES,
  parameter int V_RES     = DEF_V_RES,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic                 advance,
  input  logic [BIT_WIDTH-1:0] re_min,
  input  logic [BIT_WIDTH-1:0] im_max,
  input  logic [BIT_WIDTH-1:0] step,
  output logic [BIT_WIDTH-1:0] cur_re,
  output logic [BIT_WIDTH-1:0] cur_im,
  output logic [ADDR_W-1:0]    addr,
  output logic                 last_pixel
);

  localparam int XW = cnt_width(H_RES);
  localparam int YW = cnt_width(V_RES);

  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic [BIT_WIDTH-1:0] re_min_l;
  logic [BIT_WIDTH-1:0] step_l;
  logic                 last_col;
  logic                 last_row;

  assign last_col   = (x == XW'(H_RES - 1));
  assign last_row   = (y == YW'(V_RES - 1));
  assign last_pixel = last_col && last_row;

  // Restart loads the frame origin; advance moves one pixel along the raster,
  // wrapping to the start of the next line at the right edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      addr     <= '0;
      cur_re   <= '0;
      cur_im   <= '0;
      re_min_l <= '0;
      step_l   <= '0;
    end else if (restart) begin
      x        <= '0;
      y        <= '0;
      addr     <= '0;
      cur_re   <= re_min;
      cur_im   <= im_max;
      re_min_l <= re_min;
      step_l   <= step;
    end else if (advance && !last_pixel) begin
      addr <= addr + 1'b1;
      if (!last_col) begin
        x      <= x + 1'b1;
        cur_re <= cur_re + step_l;
      end else begin
        x      <= '0;
        y      <= y + 1'b1;
        cur_re <= re_min_l;
        cur_im <= cur_im - step_l;
      end
    end
  end

endmodule

// File: rtl/mandelbrot_pixel_scanner.sv
// Upstream sequencer for the Mandelbrot iteration core: walks the raster,
// hands each pixel's coordinate to the core, and writes the returned
// iteration count to the frame buffer at the pixel's linear address.
module mandelbrot_pixel_scanner
  import mandelbrot_pkg::*;
#(
  parameter int BIT_WIDTH       = DEF_BIT_WIDTH,
  parameter int FLOAT_PRECISION = DEF_FLOAT_PRECISION,
  parameter int H_RES           = DEF_H_RES,
  parameter int V_RES           = DEF_V_RES,
  parameter int ADDR_W          = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic [BIT_WIDTH-1:0] re_min,
  input  logic [BIT_WIDTH-1:0] im_max,
  input  logic [BIT_WIDTH-1:0] step,
  mandelbrot_pixel_scanner_if.master bus,
  output logic                 busy,
  output logic                 frame_done,
  output state_t               dbg_state
);

  // Parameter sanity: the fraction must leave an integer part, and the
  // address must reach the last pixel.
  if (FLOAT_PRECISION >= BIT_WIDTH) begin : g_bad_precision
    $error("FLOAT_PRECISION must be smaller than BIT_WIDTH");
  end
  if ((H_RES * V_RES) > (2 ** ADDR_W)) begin : g_bad_addr_w
    $error("ADDR_W too narrow for H_RES*V_RES");
  end

  state_t               state;
  state_t               state_nxt;
  logic                 restart;
  logic                 advance;
  logic                 start_req;
  logic                 capture;
  logic                 coord_valid;
  logic [BIT_WIDTH-1:0] cur_re;
  logic [BIT_WIDTH-1:0] cur_im;
  logic [ADDR_W-1:0]    addr;
  logic                 last_pixel;
  logic [ADDR_W-1:0]    fb_addr_q;
  logic [BIT_WIDTH-1:0] fb_data_q;

  mandelbrot_coord_stepper #(
    .BIT_WIDTH (BIT_WIDTH),
    .H_RES     (H_RES),
    .V_RES     (V_RES),
    .ADDR_W    (ADDR_W)
  ) u_stepper (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .advance    (advance),
    .re_min     (re_min),
    .im_max     (im_max),
    .step       (step),
    .cur_re     (cur_re),
    .cur_im     (cur_im),
    .addr       (addr),
    .last_pixel (last_pixel)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and per-state strobes. A stale calc_out_rdy from the
  // previous pixel is never taken as completion because WAIT_RES is only
  // reached after the core has dropped calc_rdy in WAIT_ACC.
  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    advance   = 1'b0;
    start_req = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          restart   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.calc_rdy) begin
          start_req = 1'b1;
          state_nxt = WAIT_ACC;
        end
      end
      WAIT_ACC: begin
        if (!bus.calc_rdy) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (bus.calc_rdy && bus.calc_out_rdy) begin
          capture   = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (bus.fb_ready) begin
          if (last_pixel) begin
            state_nxt = DONE;
          end else begin
            advance   = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame-buffer write word, captured when the core result arrives and held
  // through any fb_ready stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else if (capture) begin
      fb_addr_q <= addr;
      fb_data_q <= bus.calc_colour;
    end
  end

  // The coordinate is shown to the core only while a pixel is in flight.
  assign coord_valid    = (state == ISSUE) || (state == WAIT_ACC) || (state == WAIT_RES);
  assign bus.calc_real  = coord_valid ? cur_re : '0;
  assign bus.calc_imag  = coord_valid ? cur_im : '0;
  assign bus.calc_start = start_req;

  assign bus.fb_addr = fb_addr_q;
  assign bus.fb_data = fb_data_q;
  assign bus.fb_we   = (state == WRITE);

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign dbg_state  = state;

endmodule
